// File: rtl/tracking_loop_scheduler_pkg.sv
// Shared types for the multi-channel tracking loop scheduler.
// Latency: none (types only).
// Backpressure: none (types only).
package tracking_loop_scheduler_pkg;

   // Outstanding loop requests for the FIFO head, bit 1 = FLL, bit 0 = DLL.
   typedef enum logic [1:0] {
      LOOP_IDLE     = 2'b00,
      LOOP_DLL_ONLY = 2'b01,
      LOOP_FLL_ONLY = 2'b10,
      LOOP_BOTH     = 2'b11
   } loop_pend_e;

endpackage

// File: rtl/tracking_loop_scheduler_tag_fifo.sv
// Generic tag FIFO between the IQ stage and the FLL/DLL dispatcher.
// Latency: a pushed entry is visible at dout the cycle after the push.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
module tracking_loop_scheduler_tag_fifo
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 2
)
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Storage, pointers and registered occupancy; simultaneous push/pop keeps the count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tracking_loop_scheduler.sv
// Time-shares one IQ stage, one FLL and one DLL among NUM_CHANNELS channel histories.
// Latency: valid->iq_start 1 cycle, iq_ready->fll/dll_start 2 cycles, last result->tracking_ready 1 cycle.
// Backpressure: iq_start held (tag stable) until iq_starting; IQ issue stalls while the tag FIFO is full.
module tracking_loop_scheduler
   import tracking_loop_scheduler_pkg::*;
#(
   parameter  int NUM_CHANNELS   = 4,
   parameter  int TAG_FIFO_DEPTH = 4,
   localparam int TAG_W          = $clog2(NUM_CHANNELS)
)
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_CHANNELS-1:0] i2q2_valid,
   output logic                    iq_start,
   output logic [TAG_W-1:0]        iq_tag,
   input  logic                    iq_starting,
   input  logic                    iq_ready,
   input  logic [TAG_W-1:0]        iq_done_tag,
   output logic                    fll_start,
   input  logic                    fll_starting,
   output logic                    dll_start,
   input  logic                    dll_starting,
   output logic [TAG_W-1:0]        loop_tag,
   input  logic                    fll_result_ready,
   input  logic [TAG_W-1:0]        fll_result_tag,
   input  logic                    dll_result_ready,
   input  logic [TAG_W-1:0]        dll_result_tag,
   output logic [NUM_CHANNELS-1:0] tracking_ready,
   output logic                    busy,
   output logic [NUM_CHANNELS-1:0] overrun,
   output logic                    spurious_result
);

   logic [NUM_CHANNELS-1:0] pending, inflight, done_fll, done_dll;
   logic [NUM_CHANNELS-1:0] pend_clr, inflight_set, fll_set, dll_set, complete;
   logic [TAG_W-1:0]        rr_ptr, arb_tag, cand, locked_tag, fifo_head;
   logic                    iq_busy, tag_lock, arb_found, accept, spur;
   logic                    fifo_full, fifo_empty, fifo_pop;
   loop_pend_e              loop_pend, loop_pend_nxt;

   // Tag is frozen once offered so a newly pending channel cannot change it before acceptance.
   assign iq_start  = (|pending) & ~iq_busy & ~fifo_full;
   assign iq_tag    = tag_lock ? locked_tag : arb_tag;
   assign accept    = iq_start & iq_starting;
   assign fll_start = loop_pend[1];
   assign dll_start = loop_pend[0];
   assign loop_tag  = fifo_empty ? '0 : fifo_head;
   assign complete  = done_fll & done_dll;
   assign tracking_ready = complete;
   assign busy      = (|pending) | (|inflight);

   // Round-robin search: first pending channel at or after rr_ptr, wrapping modulo N.
   always_comb begin
      arb_tag   = '0;
      arb_found = 1'b0;
      cand      = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         cand = TAG_W'((int'(rr_ptr) + i) % NUM_CHANNELS);
         if (!arb_found && pending[cand]) begin
            arb_found = 1'b1;
            arb_tag   = cand;
         end
      end
   end

   // Per-channel set/clear strobes; results for channels not in flight are flagged and dropped.
   always_comb begin
      pend_clr     = '0;
      inflight_set = '0;
      fll_set      = '0;
      dll_set      = '0;
      spur         = 1'b0;
      if (accept) begin
         pend_clr[iq_tag]     = 1'b1;
         inflight_set[iq_tag] = 1'b1;
      end
      if (fll_result_ready) begin
         if (inflight[fll_result_tag]) fll_set[fll_result_tag] = 1'b1;
         else                          spur = 1'b1;
      end
      if (dll_result_ready) begin
         if (inflight[dll_result_tag]) dll_set[dll_result_tag] = 1'b1;
         else                          spur = 1'b1;
      end
   end

   // Loop dispatch: reload both requests from a non-empty FIFO, pop when the last one is taken.
   always_comb begin
      loop_pend_nxt = loop_pend;
      fifo_pop      = 1'b0;
      if (loop_pend == LOOP_IDLE) begin
         loop_pend_nxt = fifo_empty ? LOOP_IDLE : LOOP_BOTH;
      end else begin
         loop_pend_nxt = loop_pend_e'(loop_pend & ~{fll_starting, dll_starting});
         fifo_pop      = (loop_pend_nxt == LOOP_IDLE);
      end
   end

   // Channel bookkeeping; a new request wins over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending         <= '0;
         inflight        <= '0;
         done_fll        <= '0;
         done_dll        <= '0;
         overrun         <= '0;
         spurious_result <= 1'b0;
      end else begin
         pending         <= i2q2_valid | (pending & ~pend_clr);
         inflight        <= (inflight & ~complete) | inflight_set;
         done_fll        <= (done_fll & ~complete) | fll_set;
         done_dll        <= (done_dll & ~complete) | dll_set;
         overrun         <= overrun | (i2q2_valid & (pending | inflight));
         spurious_result <= spurious_result | spur;
      end
   end

   // IQ issue state: busy flag, round-robin pointer, tag lock and loop request bits.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iq_busy    <= 1'b0;
         rr_ptr     <= '0;
         tag_lock   <= 1'b0;
         locked_tag <= '0;
         loop_pend  <= LOOP_IDLE;
      end else begin
         if (accept) begin
            iq_busy <= 1'b1;
            rr_ptr  <= (iq_tag == TAG_W'(NUM_CHANNELS-1)) ? '0 : iq_tag + TAG_W'(1);
         end else if (iq_ready) begin
            iq_busy <= 1'b0;
         end
         if (accept) begin
            tag_lock <= 1'b0;
         end else if (iq_start) begin
            tag_lock   <= 1'b1;
            locked_tag <= iq_tag;
         end
         loop_pend <= loop_pend_nxt;
      end
   end

   tracking_loop_scheduler_tag_fifo #(
      .DEPTH (TAG_FIFO_DEPTH),
      .WIDTH (TAG_W)
   ) u_tag_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (iq_ready),
      .din     (iq_done_tag),
      .pop     (fifo_pop),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_tracking_loop_scheduler.sv
// Directed bench for the tracking loop scheduler with hand-computed expectations.
// Latency: n/a.
// Backpressure: bench drives the *_starting handshakes explicitly.
module tb_tracking_loop_scheduler;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [3:0] i2q2_valid = '0;
   logic       iq_start;
   logic [1:0] iq_tag;
   logic       iq_starting = 1'b0;
   logic       iq_ready = 1'b0;
   logic [1:0] iq_done_tag = '0;
   logic       fll_start, dll_start;
   logic       fll_starting = 1'b0;
   logic       dll_starting = 1'b0;
   logic [1:0] loop_tag;
   logic       fll_result_ready = 1'b0;
   logic [1:0] fll_result_tag = '0;
   logic       dll_result_ready = 1'b0;
   logic [1:0] dll_result_tag = '0;
   logic [3:0] tracking_ready;
   logic       busy;
   logic [3:0] overrun;
   logic       spurious_result;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int ch;
      int iq_lat;
      int fll_d;
      int dll_d;
      int exp_k;   // result-loop iteration at which tracking_ready must be seen
   } vec_t;
   vec_t vecs[4];

   tracking_loop_scheduler #(.NUM_CHANNELS(4), .TAG_FIFO_DEPTH(4)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .i2q2_valid       (i2q2_valid),
      .iq_start         (iq_start),
      .iq_tag           (iq_tag),
      .iq_starting      (iq_starting),
      .iq_ready         (iq_ready),
      .iq_done_tag      (iq_done_tag),
      .fll_start        (fll_start),
      .fll_starting     (fll_starting),
      .dll_start        (dll_start),
      .dll_starting     (dll_starting),
      .loop_tag         (loop_tag),
      .fll_result_ready (fll_result_ready),
      .fll_result_tag   (fll_result_tag),
      .dll_result_ready (dll_result_ready),
      .dll_result_tag   (dll_result_tag),
      .tracking_ready   (tracking_ready),
      .busy             (busy),
      .overrun          (overrun),
      .spurious_result  (spurious_result)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i2q2_valid = '0; iq_starting = 0; iq_ready = 0; fll_starting = 0; dll_starting = 0;
      fll_result_ready = 0; dll_result_ready = 0;
      reset_n = 1'b0;
      step(); step();
      reset_n = 1'b1;
      step();
   endtask

   // Accept the offered IQ request and report it ready the next cycle.
   task automatic iq_cycle(input int tag);
      iq_starting = 1; step(); iq_starting = 0;
      iq_ready = 1; iq_done_tag = 2'(tag); step(); iq_ready = 0;
   endtask

   task automatic drain_loops(input int cycles);
      fll_starting = 1; dll_starting = 1;
      repeat (cycles) step();
      fll_starting = 0; dll_starting = 0;
   endtask

   task automatic run_one(input vec_t v);
      int mx, pulses, seen_k;
      logic [3:0] seen_vec;
      mx = (v.fll_d > v.dll_d) ? v.fll_d : v.dll_d;
      i2q2_valid = 4'(1 << v.ch);
      check("pre_start", 32'(iq_start), 0);
      step(); i2q2_valid = '0;
      check("iq_start", 32'(iq_start), 1);
      check("iq_tag", 32'(iq_tag), v.ch);
      check("busy_start", 32'(busy), 1);
      iq_starting = 1; step(); iq_starting = 0;
      check("iq_busy_hold", 32'(iq_start), 0);
      repeat (v.iq_lat - 1) step();
      iq_ready = 1; iq_done_tag = 2'(v.ch); step(); iq_ready = 0;
      check("fll_start_t1", 32'(fll_start), 0);
      step();
      check("fll_start_t2", 32'(fll_start), 1);
      check("dll_start_t2", 32'(dll_start), 1);
      check("loop_tag", 32'(loop_tag), v.ch);
      fll_starting = 1; dll_starting = 1; step(); fll_starting = 0; dll_starting = 0;
      check("loops_taken", 32'({fll_start, dll_start}), 0);
      pulses = 0; seen_k = -1; seen_vec = '0;
      for (int k = 1; k <= mx + 3; k++) begin
         fll_result_ready = (k == v.fll_d); fll_result_tag = 2'(v.ch);
         dll_result_ready = (k == v.dll_d); dll_result_tag = 2'(v.ch);
         step();
         fll_result_ready = 0; dll_result_ready = 0;
         if (tracking_ready != 0) begin
            pulses++;
            if (seen_k < 0) begin
               seen_k = k;
               seen_vec = tracking_ready;
            end
         end
      end
      check("ready_cycle", 32'(seen_k), v.exp_k);
      check("ready_vec", 32'(seen_vec), 1 << v.ch);
      check("ready_pulses", 32'(pulses), 1);
      check("busy_end", 32'(busy), 0);
   endtask

   initial begin
      int pulses;
      vecs[0] = '{ch: 2, iq_lat: 10, fll_d: 5, dll_d: 7, exp_k: 7};
      vecs[1] = '{ch: 0, iq_lat: 1,  fll_d: 3, dll_d: 3, exp_k: 3};
      vecs[2] = '{ch: 3, iq_lat: 2,  fll_d: 6, dll_d: 1, exp_k: 6};
      vecs[3] = '{ch: 1, iq_lat: 4,  fll_d: 1, dll_d: 1, exp_k: 1};

      // Reset state
      #2;
      do_reset();
      check("rst_outputs", 32'({iq_start, iq_tag, fll_start, dll_start, loop_tag,
                                tracking_ready, busy, overrun, spurious_result}), 0);

      // Single-channel flows
      foreach (vecs[i]) run_one(vecs[i]);
      check("no_overrun_single", 32'(overrun), 0);
      check("no_spurious_single", 32'(spurious_result), 0);

      // Round robin 0,1,3 with loops stalled, then fill the FIFO with channel 2
      do_reset();
      i2q2_valid = 4'b1011; step(); i2q2_valid = '0;
      for (int i = 0; i < 3; i++) begin
         int exp_tag;
         exp_tag = (i == 2) ? 3 : i;
         check("rr_start", 32'(iq_start), 1);
         check("rr_tag", 32'(iq_tag), exp_tag);
         iq_cycle(exp_tag);
      end
      check("rr_idle", 32'(iq_start), 0);
      i2q2_valid = 4'b0100; step(); i2q2_valid = '0;
      check("fill_tag", 32'(iq_tag), 2);
      iq_cycle(2);
      check("full_stall", 32'(iq_start), 0);
      i2q2_valid = 4'b0001; step(); i2q2_valid = '0;
      check("overrun_full", 32'(overrun), 1);
      for (int i = 0; i < 3; i++) begin
         check("full_hold", 32'(iq_start), 0);
         step();
      end
      check("head_tag", 32'(loop_tag), 0);
      check("head_req", 32'({fll_start, dll_start}), 3);
      fll_starting = 1; dll_starting = 1;
      check("pop_cycle", 32'(iq_start), 0);
      step(); fll_starting = 0; dll_starting = 0;
      check("resume_start", 32'(iq_start), 1);
      check("resume_tag", 32'(iq_tag), 0);
      check("next_head", 32'(loop_tag), 1);
      check("reload_gap", 32'(fll_start), 0);
      step();
      check("reload", 32'({fll_start, dll_start}), 3);

      // Simultaneous results for different tags
      do_reset();
      i2q2_valid = 4'b1010; step(); i2q2_valid = '0;
      check("sim_tag1", 32'(iq_tag), 1);
      iq_cycle(1);
      check("sim_tag3", 32'(iq_tag), 3);
      iq_cycle(3);
      drain_loops(6);
      check("sim_drained", 32'({fll_start, dll_start}), 0);
      fll_result_ready = 1; fll_result_tag = 2'd1; dll_result_ready = 1; dll_result_tag = 2'd3;
      step();
      fll_result_tag = 2'd3; dll_result_tag = 2'd1;
      check("sim_half", 32'(tracking_ready), 0);
      step();
      fll_result_ready = 0; dll_result_ready = 0;
      check("sim_both", 32'(tracking_ready), 4'b1010);
      step();
      check("sim_clear", 32'(tracking_ready), 0);
      check("sim_idle", 32'(busy), 0);
      check("sim_no_spur", 32'(spurious_result), 0);

      // Re-request while in flight: overrun and two completions; then a spurious result
      do_reset();
      pulses = 0;
      i2q2_valid = 4'b0001; step(); i2q2_valid = '0;
      iq_cycle(0);
      drain_loops(4);
      i2q2_valid = 4'b0001; step(); i2q2_valid = '0;
      check("ovr_flag", 32'(overrun), 1);
      check("ovr_pending", 32'(iq_start), 1);
      fll_result_ready = 1; dll_result_ready = 1; fll_result_tag = 2'd0; dll_result_tag = 2'd0;
      step(); fll_result_ready = 0; dll_result_ready = 0;
      if (tracking_ready == 4'b0001) pulses++;
      step();
      check("ovr_second_tag", 32'(iq_tag), 0);
      iq_cycle(0);
      drain_loops(4);
      fll_result_ready = 1; dll_result_ready = 1;
      step(); fll_result_ready = 0; dll_result_ready = 0;
      if (tracking_ready == 4'b0001) pulses++;
      step();
      check("ovr_twice", 32'(pulses), 2);
      check("ovr_idle", 32'(busy), 0);
      check("spur_before", 32'(spurious_result), 0);
      dll_result_ready = 1; dll_result_tag = 2'd2; step(); dll_result_ready = 0;
      check("spur_after", 32'(spurious_result), 1);
      check("spur_no_ready", 32'(tracking_ready), 0);

      // Async reset mid-dispatch
      do_reset();
      i2q2_valid = 4'b0010; step(); i2q2_valid = '0;
      iq_cycle(1);
      step();
      check("pre_rst_fll", 32'(fll_start), 1);
      #3 reset_n = 1'b0;
      #1;
      check("async_rst", 32'({iq_start, iq_tag, fll_start, dll_start, loop_tag,
                              tracking_ready, busy, overrun, spurious_result}), 0);
      step(); step();
      reset_n = 1'b1;
      pulses = 0;
      repeat (10) begin
         step();
         if (tracking_ready != 0) pulses++;
      end
      check("post_rst_pulses", 32'(pulses), 0);
      check("post_rst_busy", 32'(busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
